// File: rtl/regfile_2w3r.sv
// regfile_2w3r
// ------------
// Decode-stage register file with three combinational read ports and two
// synchronous write ports. Port A carries ALU writeback and has priority over
// port B, which carries load/store base-update writeback. The PC_REG address
// is virtual: reads of it return the r15 input, and writes to it are dropped.
// When BYPASS is enabled, a read of a register being written in the same
// cycle returns the incoming write data instead of the stored value.
//
// Parameters
//   WIDTH   data width of every register and port
//   ADDR_W  address width, register count is 2**ADDR_W
//   PC_REG  address that reads back r15, writes to it are discarded
//   BYPASS  1 = reads see same-cycle write data, 0 = stored value only
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           synchronous active-high clear of every register
//   ra1, ra2, ra3   read addresses
//   rd1, rd2, rd3   combinational read data
//   wea, waa, wda   port A write enable / address / data (priority port)
//   web, wab, wdb   port B write enable / address / data
//   r15             current PC+8 value from the fetch path
module regfile_2w3r #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int PC_REG = 15,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic [WIDTH-1:0]  rd3,
    input  logic              wea,
    input  logic [ADDR_W-1:0] waa,
    input  logic [WIDTH-1:0]  wda,
    input  logic              web,
    input  logic [ADDR_W-1:0] wab,
    input  logic [WIDTH-1:0]  wdb,
    input  logic [WIDTH-1:0]  r15
);

    localparam int               NREGS   = 2 ** ADDR_W;
    localparam int               NREAD   = 3;
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

    logic [WIDTH-1:0]  mem    [NREGS];
    logic [ADDR_W-1:0] ra_arr [NREAD];
    logic [WIDTH-1:0]  rd_arr [NREAD];

    logic write_a;
    logic write_b;
    logic bypass_on;

    // Effective write strobes. A write aimed at the PC address is dropped,
    // and port B loses silently when both ports target the same register.
    assign write_a = wea && (waa != PC_ADDR);
    assign write_b = web && (wab != PC_ADDR) && !(wea && (waa == wab));

    // Forwarding is suppressed while reset is high: during that cycle reads
    // must show the pre-reset stored contents, not the doomed write data.
    assign bypass_on = (BYPASS != 0) && !reset;

    // Storage update. Reset clears every entry, including the unused PC
    // slot, and overrides both write ports for the cycle it is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (write_a) begin
                mem[waa] <= wda;
            end
            if (write_b) begin
                mem[wab] <= wdb;
            end
        end
    end

    assign ra_arr[0] = ra1;
    assign ra_arr[1] = ra2;
    assign ra_arr[2] = ra3;

    // Read muxes, one per port, in priority order: PC override, port A
    // forward, port B forward, stored value. Because port A is checked
    // first, a collision forwards port A data, matching what gets stored.
    // A write aimed at the PC address can never be forwarded, since the
    // PC override wins for that read address before any bypass check.
    always_comb begin
        for (int p = 0; p < NREAD; p++) begin
            rd_arr[p] = mem[ra_arr[p]];
            if (ra_arr[p] == PC_ADDR) begin
                rd_arr[p] = r15;
            end else if (bypass_on && wea && (waa == ra_arr[p])) begin
                rd_arr[p] = wda;
            end else if (bypass_on && web && (wab == ra_arr[p])) begin
                rd_arr[p] = wdb;
            end
        end
    end

    assign rd1 = rd_arr[0];
    assign rd2 = rd_arr[1];
    assign rd3 = rd_arr[2];

endmodule

// File: tb/tb_regfile_2w3r.sv
// tb_regfile_2w3r
// ---------------
// Self-checking bench for regfile_2w3r. Two instances share every input:
// one built with BYPASS=1 and one with BYPASS=0, so each vector states the
// expected read data for both flavours. Inputs change on the falling edge
// and outputs are compared shortly after, well before the next rising edge.
module tb_regfile_2w3r;

    localparam int W = 32;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [A-1:0] ra1, ra2, ra3;
    logic [A-1:0] waa, wab;
    logic         wea, web;
    logic [W-1:0] wda, wdb, r15;
    logic [W-1:0] rd1_b, rd2_b, rd3_b;
    logic [W-1:0] rd1_n, rd2_n, rd3_n;

    int vectors_applied = 0;
    int miscompares     = 0;
    int checks          = 0;

    typedef struct {
        logic         rst;
        logic         wea;
        logic [A-1:0] waa;
        logic [W-1:0] wda;
        logic         web;
        logic [A-1:0] wab;
        logic [W-1:0] wdb;
        logic [A-1:0] ra1, ra2, ra3;
        logic [W-1:0] r15;
        logic [W-1:0] eb1, eb2, eb3;
        logic [W-1:0] en1, en2, en3;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    regfile_2w3r #(.WIDTH(W), .ADDR_W(A), .PC_REG(15), .BYPASS(1)) dut_byp (
        .clk(clk), .reset(reset),
        .ra1(ra1), .ra2(ra2), .ra3(ra3),
        .rd1(rd1_b), .rd2(rd2_b), .rd3(rd3_b),
        .wea(wea), .waa(waa), .wda(wda),
        .web(web), .wab(wab), .wdb(wdb),
        .r15(r15)
    );

    regfile_2w3r #(.WIDTH(W), .ADDR_W(A), .PC_REG(15), .BYPASS(0)) dut_nob (
        .clk(clk), .reset(reset),
        .ra1(ra1), .ra2(ra2), .ra3(ra3),
        .rd1(rd1_n), .rd2(rd2_n), .rd3(rd3_n),
        .wea(wea), .waa(waa), .wda(wda),
        .web(web), .wab(wab), .wdb(wdb),
        .r15(r15)
    );

    function automatic vec_t mk(
        input logic rst, input logic we_a, input logic [A-1:0] wa_a, input logic [W-1:0] wd_a,
        input logic we_b, input logic [A-1:0] wa_b, input logic [W-1:0] wd_b,
        input logic [A-1:0] a1, input logic [A-1:0] a2, input logic [A-1:0] a3,
        input logic [W-1:0] pc,
        input logic [W-1:0] b1, input logic [W-1:0] b2, input logic [W-1:0] b3,
        input logic [W-1:0] n1, input logic [W-1:0] n2, input logic [W-1:0] n3);
        vec_t v;
        v.rst = rst; v.wea = we_a; v.waa = wa_a; v.wda = wd_a;
        v.web = we_b; v.wab = wa_b; v.wdb = wd_b;
        v.ra1 = a1; v.ra2 = a2; v.ra3 = a3; v.r15 = pc;
        v.eb1 = b1; v.eb2 = b2; v.eb3 = b3;
        v.en1 = n1; v.en2 = n2; v.en3 = n3;
        return v;
    endfunction

    function automatic logic [W-1:0] pattern(input int i);
        return 32'hC0DE_0000 | W'(i) | (W'(i) << 12);
    endfunction

    task automatic check_output(input string name, input logic [W-1:0] actual,
                                input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic rst, input logic we_a, input logic [A-1:0] wa_a,
                         input logic [W-1:0] wd_a, input logic we_b, input logic [A-1:0] wa_b,
                         input logic [W-1:0] wd_b, input logic [A-1:0] a1,
                         input logic [A-1:0] a2, input logic [A-1:0] a3,
                         input logic [W-1:0] pc);
        @(negedge clk);
        reset = rst; wea = we_a; waa = wa_a; wda = wd_a;
        web = we_b; wab = wa_b; wdb = wd_b;
        ra1 = a1; ra2 = a2; ra3 = a3; r15 = pc;
        #2;
        vectors_applied++;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        drive(v.rst, v.wea, v.waa, v.wda, v.web, v.wab, v.wdb, v.ra1, v.ra2, v.ra3, v.r15);
        check_output($sformatf("v%0d byp rd1", idx), rd1_b, v.eb1);
        check_output($sformatf("v%0d byp rd2", idx), rd2_b, v.eb2);
        check_output($sformatf("v%0d byp rd3", idx), rd3_b, v.eb3);
        check_output($sformatf("v%0d nob rd1", idx), rd1_n, v.en1);
        check_output($sformatf("v%0d nob rd2", idx), rd2_n, v.en2);
        check_output($sformatf("v%0d nob rd3", idx), rd3_n, v.en3);
    endtask

    // Read a triple of addresses with no writes and expect the same data
    // from both instances.
    task automatic read_triple(input string tag, input logic [A-1:0] a1, input logic [A-1:0] a2,
                               input logic [A-1:0] a3, input logic [W-1:0] e1,
                               input logic [W-1:0] e2, input logic [W-1:0] e3);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a1, a2, a3, 32'h0000_1008);
        check_output({tag, " byp rd1"}, rd1_b, e1);
        check_output({tag, " byp rd2"}, rd2_b, e2);
        check_output({tag, " byp rd3"}, rd3_b, e3);
        check_output({tag, " nob rd1"}, rd1_n, e1);
        check_output({tag, " nob rd2"}, rd2_n, e2);
        check_output({tag, " nob rd3"}, rd3_n, e3);
    endtask

    localparam logic [W-1:0] PC0 = 32'h0000_1008;
    localparam logic [W-1:0] PC1 = 32'h0000_0208;
    localparam logic [W-1:0] DB  = 32'hDEAD_BEEF;
    localparam logic [W-1:0] D12 = 32'h1234_5678;
    localparam logic [W-1:0] AA  = 32'hAAAA_AAAA;
    localparam logic [W-1:0] FIV = 32'h5555_5555;

    initial begin
        reset = 1'b0; wea = 1'b0; web = 1'b0; waa = '0; wab = '0;
        wda = '0; wdb = '0; ra1 = '0; ra2 = '0; ra3 = '0; r15 = PC0;

        // Reset cycle: only the PC address is defined before the first clear.
        vecs.push_back(mk(1, 0,0,0, 0,0,0, 15,15,15, PC0, PC0,PC0,PC0, PC0,PC0,PC0));
        // Sweep addresses 0..14 after reset.
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(0, 0,0,0, 0,0,0, A'(3*k), A'(3*k+1), A'(3*k+2), PC0,
                              0,0,0, 0,0,0));
        end
        // Dual write to distinct addresses, then read back.
        vecs.push_back(mk(0, 1,2,DB, 1,3,D12, 2,3,4, PC0, DB,D12,0, 0,0,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 2,3,15, PC0, DB,D12,PC0, DB,D12,PC0));
        // Collision on address 5: port A wins in storage and in forwarding.
        vecs.push_back(mk(0, 1,5,AA, 1,5,FIV, 5,5,2, PC0, AA,AA,DB, 0,0,DB));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 5,3,2, PC0, AA,D12,DB, AA,D12,DB));
        // Bypass versus stored value on address 7.
        vecs.push_back(mk(0, 1,7,32'h11, 0,0,0, 7,7,7, PC0, 32'h11,32'h11,32'h11, 0,0,0));
        vecs.push_back(mk(0, 1,7,32'h77, 0,0,0, 7,5,6, PC0, 32'h77,AA,0, 32'h11,AA,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 7,7,7, PC0, 32'h77,32'h77,32'h77, 32'h77,32'h77,32'h77));
        // Port B forwarding alone.
        vecs.push_back(mk(0, 0,0,0, 1,8,32'h88, 8,9,7, PC0, 32'h88,0,32'h77, 0,0,32'h77));
        // PC protection: writes to 15 never land and never forward.
        vecs.push_back(mk(0, 1,15,32'hFFFF_FFFF, 0,0,0, 15,7,8, PC1, PC1,32'h77,32'h88, PC1,32'h77,32'h88));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 15,14,13, PC1, PC1,0,0, PC1,0,0));
        vecs.push_back(mk(0, 1,10,32'hA0, 1,15,32'hBBBB, 15,10,15, PC0, PC0,32'hA0,PC0, PC0,0,PC0));
        // Reset beats a concurrent write; no forwarding while reset is high.
        vecs.push_back(mk(0, 1,4,32'h99, 0,0,0, 4,10,2, PC0, 32'h99,32'hA0,DB, 0,32'hA0,DB));
        vecs.push_back(mk(1, 1,4,32'h44, 0,0,0, 4,4,2, PC0, 32'h99,32'h99,DB, 32'h99,32'h99,DB));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 4,2,7, PC0, 0,0,0, 0,0,0));
        // Reset held three cycles while both ports keep writing.
        vecs.push_back(mk(0, 1,4,32'h99, 1,6,32'h66, 4,6,1, PC0, 32'h99,32'h66,0, 0,0,0));
        vecs.push_back(mk(1, 1,4,32'h44, 1,6,32'h60, 4,6,15, PC0, 32'h99,32'h66,PC0, 32'h99,32'h66,PC0));
        vecs.push_back(mk(1, 1,4,32'h45, 1,6,32'h61, 4,6,15, PC0, 0,0,PC0, 0,0,PC0));
        vecs.push_back(mk(1, 1,4,32'h46, 0,0,0, 4,6,3, PC0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 4,6,3, PC0, 0,0,0, 0,0,0));
        // Port B forwards while port A writes elsewhere; shared read addresses.
        vecs.push_back(mk(0, 1,1,32'h101, 1,2,32'h202, 2,2,1, PC0, 32'h202,32'h202,32'h101, 0,0,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 1,2,2, PC0, 32'h101,32'h202,32'h202, 32'h101,32'h202,32'h202));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i], i);
        end

        // Fill every real register using both ports at once, then read all back.
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, 1'b1, A'(k), pattern(k), 1'b1, A'(k + 7), pattern(k + 7),
                  15, 15, 15, PC0);
        end
        drive(1'b0, 1'b1, 4'd14, pattern(14), 1'b0, '0, '0, 15, 15, 15, PC0);
        for (int a = 0; a < 15; a += 3) begin
            read_triple($sformatf("fill a%0d", a), A'(a), A'(a + 1), A'(a + 2),
                        pattern(a), pattern(a + 1), pattern(a + 2));
        end

        // Long reset with writes every cycle: the first reset cycle still
        // shows stored data, and nothing written during reset survives.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, A'(k), 32'hFFFF_FFFF, 1'b1, A'(k + 1), 32'hEEEE_EEEE,
                  0, 1, 15, PC0);
            if (k == 0) begin
                check_output("rst0 byp rd1", rd1_b, pattern(0));
                check_output("rst0 nob rd2", rd2_n, pattern(1));
            end
        end
        for (int a = 0; a < 15; a += 3) begin
            read_triple($sformatf("clr a%0d", a), A'(a), A'(a + 1), A'(a + 2), 0, 0, 0);
        end
        read_triple("clr pc", 15, 0, 15, PC0, 0, PC0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_2w3r.md
# regfile_2w3r

Parametrised successor to the processor's single-write register file. It has three combinational read ports, two synchronous write ports with fixed priority, optional write-to-read bypass, synchronous clear, and the PC read override. It sits in the decode stage: read ports feed operand selection, and write ports take ALU result writeback (port A) and load/store base-update writeback (port B).

## Interface
- WIDTH, 32: data width of every register and port.
- ADDR_W, 4: address width; register count is 2**ADDR_W.
- PC_REG, 15: address that reads back the R15 input; writes to it are discarded.
- BYPASS, 1: 1 = reads see same-cycle write data; 0 = reads see stored value only.

- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high; clears all registers.
- RA1, RA2, RA3  in  ADDR_W each  read addresses.
- RD1, RD2, RD3  out  WIDTH each  read data, combinational.
- WEA  in  1  write enable, port A (priority port).
- WAA  in  ADDR_W  write address, port A.
- WDA  in  WIDTH  write data, port A.
- WEB  in  1  write enable, port B.
- WAB  in  ADDR_W  write address, port B.
- WDB  in  WIDTH  write data, port B.
- R15  in  WIDTH  current PC+8 value from the fetch path.

## Operation
- Storage: 2**ADDR_W registers of WIDTH bits. The PC_REG entry exists but is never written and never read.
- Write, on the CLK rising edge with RESET low:
  - Port A writes mem[WAA]=WDA if WEA=1.
  - Port B writes mem[WAB]=WDB if WEB=1.
  - Both enabled with WAA==WAB: port A wins and port B is dropped silently.
  - Write address == PC_REG: that port's write is discarded. Stored PC_REG entry stays 0.
- Reset: RESET=1 at a rising edge sets every register to 0. RESET overrides both write ports in that cycle.
- Read, per port n, evaluated in this priority order:
  1. RAn==PC_REG: RDn=R15. Applies regardless of BYPASS or RESET.
  2. BYPASS=1, RESET=0, WEA=1, WAA==RAn: RDn=WDA.
  3. BYPASS=1, RESET=0, WEB=1, WAB==RAn, and not overridden by port A: RDn=WDB.
  4. Otherwise: RDn=mem[RAn].
- Bypass never forwards a write aimed at PC_REG. Rule 1 covers that address first.
- All three read ports are independent. Identical addresses on several ports return identical data.
- No X propagation: every register is defined after the first reset. Before the first reset, contents are unspecified except that RDn=R15 at PC_REG.

## Timing
- Write latency: data is stored at the edge where the enable is sampled. A BYPASS=0 read returns it from the next cycle.
- BYPASS=1: read returns the write data in the same cycle (zero-cycle, combinational path WDx->RDn).
- Reset latency: outputs for non-PC addresses read 0 in the cycle after the RESET edge. During the RESET-high cycle, reads return pre-reset stored values, with no bypass.
- RESET asserted for several cycles: registers stay 0 and writes are ignored for every cycle it is high.
- Write-enable deasserted mid-burst: no partial writes. Each cycle is atomic.
- Read paths are purely combinational from RAn, R15, write-port inputs and storage. There is no registered output.
- Critical path (BYPASS=1): WAA compare -> 3-way mux -> RDn. It must close at the single-cycle core's clock.

## Test plan
- Reset, then read all: RESET=1 one cycle. Then RA1..RA3 sweep 0..14 -> all RD=0. RA=15 with R15=0x0000_1008 -> RD=0x0000_1008.
- Dual write, distinct addresses: WEA=1 WAA=2 WDA=0xDEADBEEF and WEB=1 WAB=3 WDB=0x12345678 in the same cycle. Next cycle RA1=2 RA2=3 -> RD1=0xDEADBEEF, RD2=0x12345678.
- Write collision: WEA=1 WEB=1 WAA=WAB=5, WDA=0xAAAA_AAAA, WDB=0x5555_5555 -> after the edge, RD(5)=0xAAAA_AAAA. With BYPASS=1 in the same cycle, RA1=5 -> RD1=0xAAAA_AAAA.
- Bypass vs no-bypass: WEA=1 WAA=7 WDA=0x77 with RA1=7 in the same cycle, prior mem[7]=0x11 -> BYPASS=1 gives RD1=0x77; BYPASS=0 gives RD1=0x11, then 0x77 next cycle.
- PC protection: WEA=1 WAA=15 WDA=0xFFFF_FFFF, R15=0x0000_0208 -> RD at address 15 = 0x0000_0208 both in that cycle and the next, and no other register changes.
- Reset beats write: RESET=1 with WEA=1 WAA=4 WDA=0x44, prior mem[4]=0x99 -> RD(4)=0x99 during that cycle and 0 next cycle. Repeat with RESET held for 3 cycles while writing -> still 0.
